// File: rtl/axis_append_sched.sv
// AXI4-Stream sequencer: forwards each packet, then appends the
// capture timestamp queued at start_packet as trailing beats.
module axis_append_sched #(
  parameter int DATA_WIDTH    = 8,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int TS_WIDTH      = 64,
  parameter int USER_WIDTH    = 1,
  parameter int TS_FIFO_DEPTH = 4,
  parameter int LITTLE_ENDIAN = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [TS_WIDTH-1:0]               timestamp,
  input  logic                              start_packet,
  input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]             s_axis_tkeep,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  input  logic [USER_WIDTH-1:0]             s_axis_tuser,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]             m_axis_tkeep,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [USER_WIDTH-1:0]             m_axis_tuser,
  output logic [$clog2(TS_FIFO_DEPTH):0]    ts_fifo_count,
  output logic                              ts_overflow
);

  localparam int N  = TS_WIDTH / DATA_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(TS_FIFO_DEPTH);
  localparam int CW = AW + 1;

  if (TS_WIDTH % DATA_WIDTH != 0) begin : g_ts_chk
    $error("TS_WIDTH must be a multiple of DATA_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, PASS, APPEND} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [TS_WIDTH-1:0]   ts_hold_q, ts_hold_d;
  logic                  miss_q, miss_d;
  logic [USER_WIDTH-1:0] user_hold_q, user_hold_d;
  logic [TS_WIDTH-1:0]   mem_q [TS_FIFO_DEPTH];
  logic [TS_WIDTH-1:0]   mem_d [TS_FIFO_DEPTH];
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [KEEP_WIDTH-1:0] keep_q, keep_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [USER_WIDTH-1:0] user_q, user_d;

  logic                  slot_free, s_rdy, s_acc;
  logic                  empty, full, pop, push_ok;
  logic                  last_word;
  logic [IW-1:0]         sel;
  logic [DATA_WIDTH-1:0] ts_word;

  always_comb begin
    slot_free = !valid_q || m_axis_tready;
    s_rdy     = rst_n && slot_free && (state_q != APPEND);
    s_acc     = s_axis_tvalid && s_rdy;
    empty     = (cnt_q == '0);
    full      = (cnt_q == CW'(TS_FIFO_DEPTH));
    pop       = s_acc && (state_q == IDLE) && !empty;
    push_ok   = start_packet && (!full || pop);
    last_word = (idx_q == IW'(N - 1));
    sel       = (LITTLE_ENDIAN != 0) ? idx_q
                                     : IW'(N - 1) - idx_q;
    ts_word   = ts_hold_q[int'(sel)*DATA_WIDTH +: DATA_WIDTH];

    state_d     = state_q;
    idx_d       = idx_q;
    ts_hold_d   = ts_hold_q;
    miss_d      = miss_q;
    user_hold_d = user_hold_q;
    mem_d       = mem_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q + CW'(push_ok) - CW'(pop);
    ovf_d       = start_packet && full && !pop;
    data_d      = data_q;
    keep_d      = keep_q;
    valid_d     = valid_q;
    last_d      = last_q;
    user_d      = user_q;

    if (push_ok) begin
      mem_d[wr_q] = timestamp;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;

    if (slot_free) begin
      valid_d = 1'b0;
      unique case (state_q)
        IDLE, PASS: begin
          if (s_acc) begin
            valid_d = 1'b1;
            data_d  = s_axis_tdata;
            keep_d  = s_axis_tkeep;
            last_d  = 1'b0;
            user_d  = s_axis_tuser;
            if (state_q == IDLE) begin
              ts_hold_d = empty ? '0 : mem_q[rd_q];
              miss_d    = empty;
              state_d   = PASS;
            end
            if (s_axis_tlast) begin
              user_hold_d = s_axis_tuser;
              idx_d       = '0;
              state_d     = APPEND;
            end
          end
        end
        APPEND: begin
          valid_d = 1'b1;
          data_d  = ts_word;
          keep_d  = '1;
          last_d  = last_word;
          user_d  = '0;
          if (last_word) begin
            // missing timestamp is flagged on the error bit
            user_d  = user_hold_q | USER_WIDTH'(miss_q);
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ts_hold_q   <= '0;
      miss_q      <= 1'b0;
      user_hold_q <= '0;
      mem_q       <= '{default: '0};
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      data_q      <= '0;
      keep_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      user_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ts_hold_q   <= ts_hold_d;
      miss_q      <= miss_d;
      user_hold_q <= user_hold_d;
      mem_q       <= mem_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      user_q      <= user_d;
    end
  end

  assign s_axis_tready = s_rdy;
  assign m_axis_tdata  = data_q;
  assign m_axis_tkeep  = keep_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;
  assign m_axis_tuser  = user_q;
  assign ts_fifo_count = cnt_q;
  assign ts_overflow   = ovf_q;

endmodule

// File: doc/axis_append_sched.md
Name: axis_append_sched

Overview:
- Sequencer that stamps each AXI4-Stream packet with a capture timestamp.
- A timestamp is latched from a free-running timer on every start_packet pulse (MAC SFD) and queued in a small FIFO.
- The block forwards each packet, then appends the matching queued timestamp as extra trailing beats and moves tlast onto the final appended beat.
- Sits between the MAC RX stream and the capture DMA.

Parameters:
- DATA_WIDTH, 8, stream data width in bits.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- TS_WIDTH, 64, timestamp width; must be a multiple of DATA_WIDTH (elaboration error otherwise).
- USER_WIDTH, 1, tuser width; bit 0 is the error flag.
- TS_FIFO_DEPTH, 4, queued timestamps; power of two, at least 2.
- LITTLE_ENDIAN, 1, 1 = least significant timestamp byte first; 0 = most significant first.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- timestamp  in  TS_WIDTH  free-running timer value.
- start_packet  in  1  single-cycle packet-start strobe.
- s_axis_tdata  in  DATA_WIDTH  input data.
- s_axis_tkeep  in  KEEP_WIDTH  input keep.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input last.
- s_axis_tuser  in  USER_WIDTH  input user.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  KEEP_WIDTH  output keep.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output last.
- m_axis_tuser  out  USER_WIDTH  output user.
- ts_fifo_count  out  clog2(TS_FIFO_DEPTH)+1  queued timestamps.
- ts_overflow  out  1  one-cycle pulse when a timestamp is dropped.

Behaviour:
Reset:
- rst_n low clears everything asynchronously: all m_axis_* = 0, s_axis_tready = 0, FIFO empty, ts_fifo_count = 0, ts_overflow = 0, state = IDLE.
- Reset mid-packet discards the partial packet and all queued timestamps.

Timestamp FIFO:
- start_packet = 1 pushes timestamp, sampled that same cycle.
- If the FIFO is full and no pop occurs that cycle, the push is dropped and ts_overflow pulses the next cycle.
- Simultaneous push and pop is legal: count is unchanged; a push when full succeeds if a pop happens the same cycle.
- Pointers wrap modulo TS_FIFO_DEPTH.

Output stage:
- Single registered output stage; latency input→output is 1 cycle.
- Output register loads when !m_axis_tvalid || m_axis_tready ("slot free").
- m_axis_tvalid holds, and all m_axis_* stay stable, until m_axis_tready.

State machine:
- IDLE:
  - s_axis_tready = slot free.
  - On the first accepted beat: pop the FIFO head into ts_hold and set miss = 0.
  - If the FIFO is empty: ts_hold = 0, miss = 1.
  - Forward the beat. If its tlast = 1, go to APPEND; else go to PASS.
- PASS:
  - s_axis_tready = slot free; beats are forwarded unchanged with m_axis_tlast forced to 0.
  - On the accepted beat with tlast = 1: record user_hold = s_axis_tuser, go to APPEND with beat counter idx = 0.
- APPEND:
  - s_axis_tready = 0.
  - Each free slot emits timestamp word idx, with tkeep all ones, tlast = (idx == TS_WIDTH/DATA_WIDTH-1), tuser = 0.
  - Word selection:
    - LITTLE_ENDIAN = 1: word k = ts_hold[k*DATA_WIDTH +: DATA_WIDTH].
    - LITTLE_ENDIAN = 0: word k = word (N-1-k), where N = TS_WIDTH/DATA_WIDTH.
  - On the final word: tuser = user_hold | {miss in bit 0}; return to IDLE.
- Single-beat packets (tlast on the first beat) go IDLE→APPEND directly; the forwarded beat has tlast = 0.
- start_packet is accepted in every state, including APPEND and backpressure stalls.

Test Plan:
- DATA_WIDTH = 8, TS_WIDTH = 32, little-endian.
  - start_packet with timestamp = 0x11223344, then packet AA BB CC (last on CC), m_axis_tready = 1 → output AA BB CC 44 33 22 11; tlast only on 11; tuser = 0; ts_fifo_count goes 1 → 0.
- Same setup with LITTLE_ENDIAN = 0 → appended order 11 22 33 44.
- Packet with no prior start_packet, s_axis_tuser = 0 → appended 00 00 00 00; tuser[0] = 1 on the final beat.
- Five start_packet pulses with timestamps 1..5 and no packets, depth 4 → ts_fifo_count = 4; one ts_overflow pulse on the fifth; next four packets carry timestamps 1, 2, 3, 4.
- m_axis_tready toggled 1010… across a 3-beat packet plus its append → no lost or duplicated beats; outputs stable while stalled; s_axis_tready = 0 for all 4 append beats.
- rst_n asserted low during append beat 2 → m_axis_tvalid = 0 immediately; ts_fifo_count = 0; next packet with a fresh timestamp 0xDEADBEEF is appended correctly.
